// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the analog test-mux sweep controller.
package mux_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int SLOT_W = 4;
  localparam logic [SLOT_W-1:0] TEMP_SLOT_ID = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_SETTLE,
    S_PRESENT
  } state_t;
endpackage

// File: rtl/mux_seq_next_slot.sv
// Lowest enabled slot in a 9-bit mask, either from slot 0 or strictly above i_cur.
module mux_seq_next_slot
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH:0]   i_mask,
  input  logic [SLOT_W-1:0] i_cur,
  input  logic              i_from_start,
  output logic [SLOT_W-1:0] o_idx,
  output logic              o_found
);
  // Scan high to low so the lowest qualifying bit is the one left standing.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_CH; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (SLOT_W'(i) > i_cur))) begin
        o_found = 1'b1;
        o_idx   = SLOT_W'(i);
      end
    end
  end
endmodule

// File: rtl/mux_sequencer.sv
// Test-mux sweep controller: break-before-make channel stepping, settle, capture, valid/ready out.
// Temperature slot is present only when MUX_SEQ_TEMP_EN is defined.
module mux_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [7:0]  CHEN,
  input  logic        TEMPEN,
  input  logic [15:0] MUX_IN,
  input  logic        SAMPLE_READY,
  output logic [7:0]  ATMCHSEL,
  output logic        TEMPSEL,
  output logic [15:0] SAMPLE_DATA,
  output logic [3:0]  SAMPLE_CH,
  output logic        SAMPLE_VALID,
  output logic        SWEEP_DONE,
  output logic        BUSY
);
  localparam int CNT_W = 8;

  state_t              r_state;
  logic [NUM_CH:0]     r_mask;
  logic [SLOT_W-1:0]   r_cur;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_sel;
  logic [15:0]         r_data;
  logic [SLOT_W-1:0]   r_ch;
  logic                r_valid;
  logic                r_done;
  logic                r_busy;

  logic [NUM_CH:0]     w_eff;
  logic [NUM_CH:0]     w_search_mask;
  logic [SLOT_W-1:0]   w_nxt;
  logic                w_found;

`ifdef MUX_SEQ_TEMP_EN
  logic r_tempsel;
  assign w_eff   = {TEMPEN, CHEN};
  assign TEMPSEL = r_tempsel;
`else
  logic w_unused_tempen;
  assign w_unused_tempen = TEMPEN;
  assign w_eff   = {1'b0, CHEN};
  assign TEMPSEL = 1'b0;
`endif

  // One search unit: picks the first slot from the live mask in IDLE, then advances over the latched one.
  assign w_search_mask = (r_state == S_IDLE) ? w_eff : r_mask;

  mux_seq_next_slot u_next (
    .i_mask       (w_search_mask),
    .i_cur        (r_cur),
    .i_from_start (r_state == S_IDLE),
    .o_idx        (w_nxt),
    .o_found      (w_found)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MUX_SEQ_TEMP_EN
      r_tempsel <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ENABLE && w_found) begin
            r_mask  <= w_eff;
            r_cur   <= w_nxt;
            r_busy  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          r_sel   <= (r_cur == TEMP_SLOT_ID) ? 8'h00 : (8'd1 << r_cur[2:0]);
`ifdef MUX_SEQ_TEMP_EN
          r_tempsel <= (r_cur == TEMP_SLOT_ID);
`endif
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_data  <= MUX_IN;
            r_ch    <= r_cur;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PRESENT: begin
          if (SAMPLE_READY) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
`ifdef MUX_SEQ_TEMP_EN
            r_tempsel <= 1'b0;
`endif
            if (w_found && ENABLE) begin
              r_cur   <= w_nxt;
              r_state <= S_GAP;
            end else begin
              // Done only when the mask is exhausted; an ENABLE drop aborts silently.
              r_done  <= !w_found;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ATMCHSEL     = r_sel;
  assign SAMPLE_DATA  = r_data;
  assign SAMPLE_CH    = r_ch;
  assign SAMPLE_VALID = r_valid;
  assign SWEEP_DONE   = r_done;
  assign BUSY         = r_busy;
endmodule

// File: tb/tb_mux_sequencer.sv
// Self-checking bench for mux_sequencer: table sweeps, random sweeps vs slot-list model, corner sequences.
module tb_mux_sequencer;
  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [7:0]  CHEN;
  logic        TEMPEN;
  logic [15:0] MUX_IN;
  logic        SAMPLE_READY;
  logic [7:0]  ATMCHSEL;
  logic        TEMPSEL;
  logic [15:0] SAMPLE_DATA;
  logic [3:0]  SAMPLE_CH;
  logic        SAMPLE_VALID;
  logic        SWEEP_DONE;
  logic        BUSY;

  localparam int S = 4;

  mux_sequencer #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CHEN(CHEN), .TEMPEN(TEMPEN),
    .MUX_IN(MUX_IN), .SAMPLE_READY(SAMPLE_READY), .ATMCHSEL(ATMCHSEL),
    .TEMPSEL(TEMPSEL), .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_CH(SAMPLE_CH),
    .SAMPLE_VALID(SAMPLE_VALID), .SWEEP_DONE(SWEEP_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Analog mux model: channel n reads 0x1000+n, temperature reads 0xBEEF.
  always_comb begin
    MUX_IN = 16'hDEAD;
    if (TEMPSEL) MUX_IN = 16'hBEEF;
    else for (int i = 0; i < 8; i++) if (ATMCHSEL == (8'd1 << i)) MUX_IN = 16'h1000 + 16'(i);
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [15:0] exp_data(input int ch);
    return (ch == 8) ? 16'hBEEF : 16'h1000 + 16'(ch);
  endfunction

  // Reference: the sweep visits every enabled slot in ascending order.
  int exp_q[$];
  function automatic void model_slots(input logic [7:0] chen, input logic tempen);
    exp_q = {};
    for (int i = 0; i < 8; i++) if (chen[i]) exp_q.push_back(i);
`ifdef MUX_SEQ_TEMP_EN
    if (tempen) exp_q.push_back(8);
`else
    if (tempen && 1'b0) exp_q.push_back(8);
`endif
  endfunction

  logic [19:0] got_q[$];
  int first_k, done_k, stalls, viol, gaps;

  task automatic run_sweep(input logic [7:0] chen, input logic tempen, input int rdy_pct);
    logic [8:0] prev_sel, sel, want;
    got_q = {}; first_k = -1; done_k = -1; stalls = 0; viol = 0; gaps = 0; prev_sel = '0;
    CHEN = chen; TEMPEN = tempen; SAMPLE_READY = 1'b1; ENABLE = 1'b1;
    @(posedge CLK);
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (SWEEP_DONE) begin done_k = k; ENABLE = 1'b0; break; end
      SAMPLE_READY = ($urandom_range(99) < rdy_pct);
      sel = {TEMPSEL, ATMCHSEL};
      if ($countones(sel) > 1) viol++;
      if (sel != 0 && prev_sel != 0 && sel != prev_sel) viol++;
      if (sel == 0 && BUSY) gaps++;
      if (SAMPLE_VALID) begin
        want = (SAMPLE_CH == 4'd8) ? 9'h100 : (9'd1 << SAMPLE_CH);
        if (sel != want) viol++;
        if (first_k < 0) first_k = k;
        if (SAMPLE_READY) got_q.push_back({SAMPLE_CH, SAMPLE_DATA});
        else stalls++;
      end
      prev_sel = sel;
      @(posedge CLK);
    end
    ENABLE = 1'b0;
    SAMPLE_READY = 1'b1;
    @(negedge CLK);
  endtask

  task automatic check_sweep(input string nm, input int n_exp);
    int mism;
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== {4'(exp_q[i]), exp_data(exp_q[i])}) mism++;
    check({nm, " nsamples"}, got_q.size(), n_exp);
    check({nm, " data_mism"}, mism, 0);
    check({nm, " done_cycle"}, done_k, n_exp * (S + 2) + stalls);
    check({nm, " sel_viol"}, viol, 0);
    check({nm, " gap_cycles"}, gaps, n_exp);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (SAMPLE_VALID) begin ok = 1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (SWEEP_DONE) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic [7:0] chen;
    logic       tempen;
    int         n;
    int         first_ch;
    int         last_ch;
  } vec_t;

  vec_t vecs[5];
  bit ok, stable;
  logic [15:0] d0;
  logic [7:0]  s0;
  int cnt;

  initial begin
    vecs[0] = '{8'h05, 1'b0, 2, 0, 2};
    vecs[1] = '{8'hFF, 1'b0, 8, 0, 7};
`ifdef MUX_SEQ_TEMP_EN
    vecs[2] = '{8'h80, 1'b1, 2, 7, 8};
`else
    vecs[2] = '{8'h80, 1'b1, 1, 7, 7};
`endif
    vecs[3] = '{8'h21, 1'b0, 2, 0, 5};
    vecs[4] = '{8'h01, 1'b0, 1, 0, 0};

    RST = 1'b1; ENABLE = 1'b0; CHEN = '0; TEMPEN = 1'b0; SAMPLE_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {ATMCHSEL, TEMPSEL, SAMPLE_DATA, SAMPLE_CH, SAMPLE_VALID, SWEEP_DONE, BUSY}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Table-driven sweeps with READY tied high.
    for (int v = 0; v < 5; v++) begin
      model_slots(vecs[v].chen, vecs[v].tempen);
      run_sweep(vecs[v].chen, vecs[v].tempen, 100);
      check_sweep($sformatf("vec%0d", v), vecs[v].n);
      check($sformatf("vec%0d first_valid", v), first_k, 5);
      check($sformatf("vec%0d first_ch", v), (got_q.size() > 0) ? 32'(got_q[0][19:16]) : 32'hFFFF, vecs[v].first_ch);
      check($sformatf("vec%0d last_ch", v), (got_q.size() > 0) ? 32'(got_q[$][19:16]) : 32'hFFFF, vecs[v].last_ch);
    end

    // Random masks and backpressure against the slot-list model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] m; logic t; int p;
      m = 8'($urandom_range(1, 255)); t = 1'($urandom_range(1)); p = $urandom_range(30, 100);
      model_slots(m, t);
      run_sweep(m, t, p);
      check_sweep($sformatf("rnd%0d", r), exp_q.size());
    end

    // READY low for 10 cycles in PRESENT.
    CHEN = 8'h03; TEMPEN = 1'b0; SAMPLE_READY = 1'b0; ENABLE = 1'b1;
    wait_valid(ok);
    check("bp valid_seen", ok, 1);
    d0 = SAMPLE_DATA; s0 = ATMCHSEL; stable = 1;
    check("bp data", d0, 16'h1000);
    check("bp sel", s0, 8'h01);
    repeat (10) begin
      @(posedge CLK); @(negedge CLK);
      if (!SAMPLE_VALID || SAMPLE_DATA !== d0 || ATMCHSEL !== s0 || SAMPLE_CH !== 4'd0) stable = 0;
    end
    check("bp stable", stable, 1);
    SAMPLE_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("bp gap", {ATMCHSEL, SAMPLE_VALID, BUSY}, {8'h00, 1'b0, 1'b1});
    @(posedge CLK); @(negedge CLK);
    check("bp next_sel", ATMCHSEL, 8'h02);
    wait_done(ok);
    ENABLE = 1'b0;
    check("bp done", ok, 1);
    @(negedge CLK);

    // ENABLE dropped during SETTLE of the first of three slots.
    CHEN = 8'h07; SAMPLE_READY = 1'b1; ENABLE = 1'b1;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    ENABLE = 1'b0;
    wait_valid(ok);
    check("endrop valid", ok, 1);
    check("endrop ch", SAMPLE_CH, 4'd0);
    @(posedge CLK); @(negedge CLK);
    check("endrop idle", {BUSY, SWEEP_DONE, SAMPLE_VALID}, 3'b000);
    cnt = 0;
    repeat (10) begin
      @(posedge CLK); @(negedge CLK);
      if (BUSY || SWEEP_DONE || ATMCHSEL != 0) cnt++;
    end
    check("endrop quiet", cnt, 0);

    // Reset during PRESENT discards the pending sample.
    CHEN = 8'h0F; SAMPLE_READY = 1'b0; ENABLE = 1'b1;
    wait_valid(ok);
    check("rst valid", ok, 1);
    ENABLE = 1'b0; RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("rst midsweep", {ATMCHSEL, TEMPSEL, SAMPLE_DATA, SAMPLE_CH, SAMPLE_VALID, SWEEP_DONE, BUSY}, 32'h0);
    RST = 1'b0; SAMPLE_READY = 1'b1;
    @(negedge CLK);

    // Empty mask never starts.
    CHEN = 8'h00; TEMPEN = 1'b0; ENABLE = 1'b1; cnt = 0;
    repeat (20) begin
      @(posedge CLK); @(negedge CLK);
      if (BUSY || SWEEP_DONE) cnt++;
    end
    check("empty quiet", cnt, 0);
    ENABLE = 1'b0;

    // Continuous operation restarts after one IDLE cycle.
    CHEN = 8'h01; ENABLE = 1'b1;
    wait_done(ok);
    check("cont done", ok, 1);
    check("cont idle_busy", BUSY, 1'b0);
    @(posedge CLK); @(negedge CLK);
    check("cont restart", {BUSY, ATMCHSEL}, {1'b1, 8'h00});
    ENABLE = 1'b0;
    wait_done(ok);
    check("cont final_done", ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
